seg7_scan_ctrl: RTL and testbench
=================================

Name: seg7_scan_ctrl

Overview:
Time-multiplexed scan controller for a common-anode multi-digit 7-segment display. One 4-bit-to-7-segment decode path (0-9 glyphs, anything else blank, active-low segments) is shared across NUM_DIGITS digits. The controller sequences digit selection with anti-ghosting blank guards, optional leading-zero suppression, and tear-free frame-synchronous value updates. It sits between the BCD value source and the board display pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (2..8)
REFRESH_DIV, 50000, clock cycles per digit slot (must be > BLANK_CYCLES)
BLANK_CYCLES, 2, guard cycles at the start of each slot with all anodes off (0 = no guard)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
digits_in  input  4*NUM_DIGITS  BCD digits; digit0 (rightmost) = [3:0]
load  input  1  1-cycle strobe to capture digits_in
enable  input  1  1 = scan, 0 = display off
lzs_en  input  1  leading-zero suppression enable
seg  output  7  segment drive, active-low, {g,f,e,d,c,b,a}
an  output  NUM_DIGITS  anode select, active-low, one-hot when driving
frame_done  output  1  1-cycle pulse at end of each full frame

Behaviour:
- Single clock. Reset is asynchronous, active-low; all state clears immediately on rst_n=0.
- Reset values: seg=7'b1111111, an=all 1s, frame_done=0. State=IDLE, idx=0, slot counter=0, shadow=0, pending_valid=0.
- Outputs are registered. On each edge they take the value for the state being entered.
- States:
  - IDLE: an all 1, seg all 1. If enable=1, next edge goes to BLANK with idx=0 and count=0. If BLANK_CYCLES=0, go straight to DRIVE.
  - BLANK: lasts BLANK_CYCLES cycles. an all 1, seg all 1. Then go to DRIVE.
  - DRIVE: lasts REFRESH_DIV-BLANK_CYCLES cycles. an[idx]=0 and all other anodes 1. seg=decode(shadow[idx]). At the end, idx increments and state goes to BLANK (or DRIVE if BLANK_CYCLES=0).
- Slot and frame length: each digit slot is exactly REFRESH_DIV cycles; a frame is NUM_DIGITS*REFRESH_DIV cycles.
- Wrap: idx goes from NUM_DIGITS-1 back to 0. frame_done pulses for the single cycle following that wrap edge.
- Decode: 0→1000000, 1→1111001, 2→0100100, 3→0110000, 4→0011001, 5→0010010, 6→0000010, 7→1111000, 8→0000000, 9→0010000. Codes 10-15 → 1111111 with the anode still driven.
- Leading-zero suppression, when lzs_en=1:
  - Contiguous zero digits from the most significant digit downward are suppressed.
  - A suppressed digit's slot keeps an all 1 and seg all 1 (power save).
  - Digit0 is never suppressed.
  - The zero mask is computed from shadow. lzs_en is sampled live.
- Load handling:
  - load in IDLE: shadow <= digits_in at that edge.
  - load while scanning: digits_in goes into a pending register and pending_valid is set. Multiple loads before the boundary: last one wins.
  - The pending value is copied to shadow on the wrap edge, so a frame never mixes old and new digits.
  - load asserted on the wrap edge itself: digits_in goes directly to shadow and wins over pending.
- enable: deasserted in any state, the next edge enters IDLE. Outputs blank, idx=0, count=0, pending applied to shadow, no frame_done.
- Reset mid-operation: immediate blank outputs and loss of pending data.

Test Plan:
(Bench parameters: NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.)
1. Reset: hold rst_n=0 with enable=1 and toggling load → seg=7'h7F, an=4'hF, frame_done=0. Deassert rst_n asynchronously mid-cycle → outputs stay reset until the first edge.
2. Basic scan: in IDLE, load digits_in=16'h1234, then enable=1.
   - Cycles 1-2: an=4'hF, seg=7'h7F.
   - Cycles 3-8: an=4'b1110, seg=0011001 ("4").
   - Cycles 11-16: an=4'b1101, seg=0110000 ("3").
   - frame_done high exactly cycle 33, then every 32 cycles.
3. Leading-zero suppression: shadow=16'h0070.
   - lzs_en=1: digit3 and digit2 slots keep an=4'hF; digit1 shows 1111000; digit0 shows 1000000.
   - lzs_en=0: digit3 shows an=4'b0111, seg=1000000.
   - shadow=16'h0000 with lzs_en=1: only digit0 is driven, seg=1000000.
4. Tear-free update: shadow=16'h1234; during the digit1 slot, load 16'h5678 → digit2 shows "2" and digit3 shows "1". The next frame shows 8,7,6,5. Repeat with load on the wrap edge → new value visible in that same frame's digit0.
5. Invalid code and enable drop: digits_in=16'h00A0 → digit1 slot has an=4'b1101, seg=7'h7F. Drop enable during a DRIVE slot → next edge an=4'hF, seg=7'h7F, no frame_done. Re-enable → scan restarts at digit0 BLANK.
6. Async reset mid-frame with pending load → outputs blank immediately. After release, shadow=0 and pending discarded.

Source files
------------

// File: rtl/seg7_scan_ctrl_if.sv
// rtl/seg7_scan_ctrl_if.sv - value-source and display-pin bundle for the 7-segment scan controller
interface seg7_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic                    load;
    logic                    enable;
    logic                    lzs_en;
    logic [6:0]              seg;
    logic [NUM_DIGITS-1:0]   an;
    logic                    frame_done;

    modport master (
        output digits_in, load, enable, lzs_en,
        input  seg, an, frame_done
    );

    modport slave (
        input  digits_in, load, enable, lzs_en,
        output seg, an, frame_done
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - multiplexed common-anode 7-segment scan controller with blank guards and LZS
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    seg7_scan_ctrl_if.slave  bus
);
    localparam int DW = 4 * NUM_DIGITS;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = $clog2(REFRESH_DIV + 1);
    localparam logic [CW-1:0] SLOT_END  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   shadow_q, shadow_d;
    logic [DW-1:0]   pending_q, pending_d;
    logic            pend_v_q, pend_v_d;
    logic [6:0]      seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic            fd_q;
    logic            wrap;
    logic            boundary;
    logic            run;
    logic [NUM_DIGITS-1:0] sup;
    logic [DW-1:0]   din;

    assign din            = bus.digits_in;
    assign bus.seg        = seg_q;
    assign bus.an         = an_q;
    assign bus.frame_done = fd_q;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b1111111;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            shadow_q  <= '0;
            pending_q <= '0;
            pend_v_q  <= 1'b0;
            seg_q     <= 7'h7F;
            an_q      <= '1;
            fd_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            pend_v_q  <= pend_v_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
            fd_q      <= wrap;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        pend_v_d  = pend_v_q;
        wrap      = 1'b0;
        boundary  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.enable) begin
                    state_d = (BLANK_CYCLES == 0) ? DRIVE : BLANK;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            end
            BLANK: begin
                if (cnt_q == BLANK_END) state_d = DRIVE;
                cnt_d = cnt_q + 1'b1;
            end
            default: begin
                if (cnt_q == SLOT_END) begin
                    cnt_d   = '0;
                    state_d = (BLANK_CYCLES == 0) ? DRIVE : BLANK;
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        wrap  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
        if (!bus.enable) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
            wrap    = 1'b0;
        end
        // Frame boundaries (wrap or leaving the scan) are the only points shadow may change while scanning
        boundary = wrap || (state_q != IDLE && !bus.enable);
        if (boundary && pend_v_q) begin
            shadow_d = pending_q;
            pend_v_d = 1'b0;
        end
        if (bus.load) begin
            if (state_q == IDLE || boundary) begin
                shadow_d = din;
            end else begin
                pending_d = din;
                pend_v_d  = 1'b1;
            end
        end
    end

    always_comb begin
        sup = '0;
        run = bus.lzs_en;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            run    = run && (shadow_d[4*i +: 4] == 4'd0);
            sup[i] = run;
        end
        an_d  = '1;
        seg_d = 7'h7F;
        if (state_d == DRIVE && !sup[idx_d]) begin
            an_d[idx_d] = 1'b0;
            seg_d       = decode(shadow_d[idx_d*4 +: 4]);
        end
    end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - directed self-checking bench for seg7_scan_ctrl
module tb_seg7_scan_ctrl;
    localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100,
                           G3 = 7'b0110000, G4 = 7'b0011001, G5 = 7'b0010010,
                           G6 = 7'b0000010, G7 = 7'b1111000, G8 = 7'b0000000,
                           OFF = 7'b1111111;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    seg7_scan_ctrl_if #(.NUM_DIGITS(4)) bus ();

    seg7_scan_ctrl #(
        .NUM_DIGITS(4),
        .REFRESH_DIV(8),
        .BLANK_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic go_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic chk(input string tag, input logic [6:0] es, input logic [3:0] ea, input logic ef);
        tests++;
        assert (bus.seg === es) else begin
            fails++;
            $error("FAIL %s seg got %b want %b (cycle %0d)", tag, bus.seg, es, cyc);
        end
        tests++;
        assert (bus.an === ea) else begin
            fails++;
            $error("FAIL %s an got %b want %b (cycle %0d)", tag, bus.an, ea, cyc);
        end
        tests++;
        assert (bus.frame_done === ef) else begin
            fails++;
            $error("FAIL %s frame_done got %b want %b (cycle %0d)", tag, bus.frame_done, ef, cyc);
        end
    endtask

    task automatic restart(input logic [15:0] val, input logic lzs);
        bus.enable = 1'b0;
        tick();
        bus.digits_in = val;
        bus.load      = 1'b1;
        tick();
        bus.load   = 1'b0;
        bus.lzs_en = lzs;
        bus.enable = 1'b1;
        cyc = 0;
    endtask

    task automatic pulse_load(input logic [15:0] val);
        bus.digits_in = val;
        bus.load      = 1'b1;
        tick();
        bus.load = 1'b0;
    endtask

    initial begin
        // 1: reset held with enable high and load toggling
        rst_n         = 1'b0;
        bus.enable    = 1'b1;
        bus.lzs_en    = 1'b0;
        bus.digits_in = 16'h9999;
        bus.load      = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.load = ~bus.load;
            tick();
        end
        chk("rst_hold", OFF, 4'hF, 1'b0);
        #2;
        rst_n      = 1'b1;
        bus.enable = 1'b0;
        bus.load   = 1'b0;
        #1;
        chk("rst_release_midcycle", OFF, 4'hF, 1'b0);
        tick();
        chk("rst_first_edge_idle", OFF, 4'hF, 1'b0);

        // 2: basic scan of 1234
        restart(16'h1234, 1'b0);
        go_to(1);  chk("scan_c1_blank", OFF, 4'hF, 1'b0);
        go_to(2);  chk("scan_c2_blank", OFF, 4'hF, 1'b0);
        go_to(3);  chk("scan_c3_d0", G4, 4'b1110, 1'b0);
        go_to(8);  chk("scan_c8_d0", G4, 4'b1110, 1'b0);
        go_to(9);  chk("scan_c9_blank", OFF, 4'hF, 1'b0);
        go_to(11); chk("scan_c11_d1", G3, 4'b1101, 1'b0);
        go_to(19); chk("scan_c19_d2", G2, 4'b1011, 1'b0);
        go_to(32); chk("scan_c32_d3", G1, 4'b0111, 1'b0);
        go_to(33); chk("scan_c33_fd", OFF, 4'hF, 1'b1);
        go_to(34); chk("scan_c34_fd_low", OFF, 4'hF, 1'b0);
        go_to(64); chk("scan_c64", G1, 4'b0111, 1'b0);
        go_to(65); chk("scan_c65_fd", OFF, 4'hF, 1'b1);

        // 3: leading-zero suppression
        restart(16'h0070, 1'b1);
        go_to(3);  chk("lzs_d0", G0, 4'b1110, 1'b0);
        go_to(11); chk("lzs_d1", G7, 4'b1101, 1'b0);
        go_to(19); chk("lzs_d2_supp", OFF, 4'hF, 1'b0);
        go_to(27); chk("lzs_d3_supp", OFF, 4'hF, 1'b0);
        bus.lzs_en = 1'b0;
        go_to(28); chk("lzs_off_live_d3", G0, 4'b0111, 1'b0);
        go_to(51); chk("lzs_off_d2", G0, 4'b1011, 1'b0);
        restart(16'h0000, 1'b1);
        go_to(3);  chk("lzs_zero_d0", G0, 4'b1110, 1'b0);
        go_to(11); chk("lzs_zero_d1", OFF, 4'hF, 1'b0);
        go_to(27); chk("lzs_zero_d3", OFF, 4'hF, 1'b0);

        // 4: tear-free updates
        restart(16'h1234, 1'b0);
        go_to(12); pulse_load(16'h5678);
        go_to(19); chk("tear_old_d2", G2, 4'b1011, 1'b0);
        go_to(27); chk("tear_old_d3", G1, 4'b0111, 1'b0);
        go_to(35); chk("tear_new_d0", G8, 4'b1110, 1'b0);
        go_to(43); chk("tear_new_d1", G7, 4'b1101, 1'b0);
        go_to(51); chk("tear_new_d2", G6, 4'b1011, 1'b0);
        go_to(59); chk("tear_new_d3", G5, 4'b0111, 1'b0);
        go_to(50); pulse_load(16'h9999);
        go_to(64); pulse_load(16'h4321);
        chk("wrapload_fd", OFF, 4'hF, 1'b1);
        go_to(67); chk("wrapload_d0", G1, 4'b1110, 1'b0);
        go_to(75); chk("wrapload_d1", G2, 4'b1101, 1'b0);

        // 5: invalid code and enable drop
        restart(16'h00A0, 1'b0);
        go_to(3);  chk("inv_d0", G0, 4'b1110, 1'b0);
        go_to(11); chk("inv_d1_blankcode", OFF, 4'b1101, 1'b0);
        go_to(20); pulse_load(16'h0007);
        go_to(32); chk("en_pre_drop_d3", G0, 4'b0111, 1'b0);
        bus.enable = 1'b0;
        tick();    chk("en_drop", OFF, 4'hF, 1'b0);
        tick();    chk("en_off_hold", OFF, 4'hF, 1'b0);
        bus.enable = 1'b1;
        cyc = 0;
        go_to(1);  chk("reen_c1_blank", OFF, 4'hF, 1'b0);
        go_to(3);  chk("reen_d0_pending", G7, 4'b1110, 1'b0);

        // 6: async reset mid-frame with pending load
        go_to(12); pulse_load(16'h8888);
        go_to(19); chk("pre_rst_d2", G0, 4'b1011, 1'b0);
        #1;
        rst_n      = 1'b0;
        bus.enable = 1'b0;
        #1;
        chk("async_rst_immediate", OFF, 4'hF, 1'b0);
        tick();
        tick();
        #2;
        rst_n      = 1'b1;
        bus.enable = 1'b1;
        cyc = 0;
        go_to(3);  chk("post_rst_d0", G0, 4'b1110, 1'b0);
        go_to(27); chk("post_rst_d3", G0, 4'b0111, 1'b0);
        go_to(35); chk("post_rst_no_pending", G0, 4'b1110, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
